apb_diag_buffer: RTL and testbench
==================================

# apb_diag_buffer

APB4 completer for the diagnostic buffer window (slave 4, 0x0002_B000–0x0002_BFFF), the responder end of the peripheral interconnect's slave-4 port. Hardware sources push 32-bit diagnostic words into a circular log; software drains it through a memory-mapped pop register. The block handles wait-state insertion, error responses, overflow/overwrite policy and a threshold interrupt.

## Interface
- DEPTH, 256: entries; power of 2, 4..4096
- IRQ_LEVEL, DEPTH/2: occupancy at which diag_irq asserts
- pclk  in  1  APB clock; sole clock
- preset  in  1  asynchronous, active-high reset
- paddr  in  32  only [11:0] decoded; [1:0] ignored
- psel, penable, pwrite  in  1 each  APB4 control
- pwdata  in  32  write data
- pstrb  in  4  ignored; all writes treated as full-word
- pready  out  1  transfer complete
- prdata  out  32  read data; 0 unless completing a read
- pslverr  out  1  error; valid only with pready
- diag_valid  in  1  push strobe, one entry per cycle, no backpressure
- diag_data  in  32  entry to log
- diag_irq  out  1  level interrupt

## Operation
- Registers, offset from paddr[11:0]:
  - 0x000 CTRL RW: [0] ENABLE (rst 0), [1] OVERWRITE (rst 0), [2] CLEAR (write-1 pulse, reads 0).
  - 0x004 STATUS: [15:0] count, [16] empty, [17] full, [18] overflow sticky (W1C via pwdata[18]); other write bits ignored, no error.
  - 0x008 DATA RO: pops oldest entry.
  - 0x00C DROPCNT RO: [15:0] saturating drop count, upper bits 0.
  - All other offsets, and writes to DATA/DROPCNT: pready=1, pslverr=1, prdata=0, no state change.
- Push (diag_valid, ENABLE=1): not full → write at wr_ptr, count+1. Full, OVERWRITE=0 → entry discarded, DROPCNT+1, overflow=1. Full, OVERWRITE=1 → slot at wr_ptr overwritten, both pointers advance, count unchanged, DROPCNT+1, overflow=1. ENABLE=0 → ignored, not counted.
- Pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
- Push and pop committing on the same edge: both pointers advance, count unchanged; if full, the push is accepted with no drop.
- CLEAR: pointers, count, overflow and DROPCNT reset to 0; a push on the same edge is discarded and not counted.
- diag_irq = ENABLE & (count >= IRQ_LEVEL | overflow).

## Timing
- Register reads and writes, and all error responses: zero wait states; pready=1 in the first access cycle.
- DATA read FSM:
  - IDLE: on access to DATA with count>0, the entry at rd_ptr is read into a holding register, rd_ptr+1 and count-1 at that edge, pready=0, then go to WAIT. If empty: pready=1, pslverr=1, stay in IDLE.
  - WAIT: pready=1, prdata=holding register, then return to IDLE.
  - The pop commits before data is returned, so a full-buffer overwrite in WAIT cannot corrupt the returned word.
- CTRL/STATUS writes take effect at the edge completing the access.
- Reset values (preset high, asynchronous): FSM IDLE; pointers, count, CTRL, overflow, DROPCNT and holding register 0; pready=0, prdata=0, pslverr=0, diag_irq=0.
- Outputs when psel=0: pready=0, prdata=0, pslverr=0.
- Reset mid-transfer aborts the transfer; the master sees pready=0.

## Configuration
- DIAG_TIMESTAMP_EN defined:
  - A 32-bit free-running counter runs from 0 after reset, +1 per cycle, and wraps.
  - Each accepted entry stores the counter value from its push cycle alongside the data, so memory is 64 bits wide.
  - New register 0x010 TS RO returns the timestamp of the entry most recently popped via DATA; it resets to 0 and is cleared by CLEAR.
- DIAG_TIMESTAMP_EN undefined: no counter, memory is 32 bits wide, and 0x010 is unmapped (pslverr).

## Structure
- Shared package diag_buffer_pkg holds:
  - register offset constants
  - CTRL and STATUS bit indices
  - FSM state enum (IDLE, WAIT)
- Sub-module diag_fifo_mem: simple dual-port RAM, DEPTH × (32 or 64) bits, synchronous write, registered read; it owns no pointer logic.

## Test plan
- Release reset, read STATUS → 0x0001_0000 with pready in the first access cycle, pslverr=0; diag_irq=0.
- Set CTRL=0x1, push 0xA5A5_0001 then 0xA5A5_0002, read DATA → first access cycle pready=0, second pready=1 with prdata=0xA5A5_0001; STATUS count=1.
- Read DATA while empty → pready=1 in first cycle, pslverr=1, prdata=0; STATUS unchanged.
- DEPTH=4, OVERWRITE=0, push 1..6 → STATUS=0x0006_0004, DROPCNT=2, pops return 1,2,3,4. Repeat with OVERWRITE=1 → pops return 3,4,5,6.
- DEPTH=4 and full, diag_valid on the same edge as a DATA pop commit → count stays 4, DROPCNT unchanged, overflow stays 0.
- Write to 0x008 and read 0x020 → pslverr=1, no state change. With DIAG_TIMESTAMP_EN, push in cycle 100 after reset, then pop → TS=100.

Source files
------------

// File: rtl/diag_buffer_pkg.sv
// Shared constants for the APB diagnostic buffer: register offsets,
// CTRL/STATUS bit indices, read FSM states and memory width.
// Macro DIAG_TIMESTAMP_EN widens memory to 64 bits (data + timestamp).
package diag_buffer_pkg;

  localparam logic [11:0] OFF_CTRL   = 12'h000;
  localparam logic [11:0] OFF_STATUS = 12'h004;
  localparam logic [11:0] OFF_DATA   = 12'h008;
  localparam logic [11:0] OFF_DROP   = 12'h00C;
  localparam logic [11:0] OFF_TS     = 12'h010;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_OVERWRITE = 1;
  localparam int CTRL_CLEAR     = 2;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;

`ifdef DIAG_TIMESTAMP_EN
  localparam int MEM_W = 64;
`else
  localparam int MEM_W = 32;
`endif

  typedef enum logic {
    IDLE,
    WAIT
  } rd_state_e;

endpackage

// File: rtl/diag_fifo_mem.sv
// Simple dual-port RAM for the diagnostic log, no pointer logic.
// Ports: clk_i, rst_i, we_i/waddr_i/wdata_i (sync write),
//        re_i/raddr_i (registered read), rdata_o (read register).
module diag_fifo_mem #(
  parameter int DEPTH = 256,
  parameter int W     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-edge overwrite of the slot being
  // popped still returns the old entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_diag_buffer.sv
// APB4 completer for the diagnostic circular log (slave 4).
// Ports: APB4 (pclk, preset, paddr, psel, penable, pwrite, pwdata,
//   pstrb, pready, prdata, pslverr), push (diag_valid, diag_data),
//   diag_irq. Macro DIAG_TIMESTAMP_EN adds per-entry timestamps + TS.
module apb_diag_buffer
  import diag_buffer_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int IRQ_LEVEL = DEPTH / 2
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  input  logic        diag_valid,
  input  logic [31:0] diag_data,
  output logic        diag_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, en_d;
  logic          ow_q, ow_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  rd_state_e     state_q, state_d;

  logic [MEM_W-1:0] mem_wdata, mem_rdata;
  logic [31:0]      reg_rdata;

  logic [11:0] off;
  logic access, hit_ctrl, hit_status, hit_data, hit_drop, hit_ts;
  logic ctrl_wr, stat_wr, clear, data_rd, map_ok;
  logic full, empty, pop, push_req;
  logic push_ok, push_ovr, push_drop, mem_we;
  logic unused_bits;

  assign unused_bits = ^{pstrb, paddr[31:12], paddr[1:0], pwdata};

  assign off        = {paddr[11:2], 2'b00};
  assign access     = psel & penable;
  assign hit_ctrl   = (off == OFF_CTRL);
  assign hit_status = (off == OFF_STATUS);
  assign hit_data   = (off == OFF_DATA);
  assign hit_drop   = (off == OFF_DROP);

  assign ctrl_wr = access & pwrite & hit_ctrl;
  assign stat_wr = access & pwrite & hit_status;
  assign clear   = ctrl_wr & pwdata[CTRL_CLEAR];
  assign data_rd = access & ~pwrite & hit_data;
  assign map_ok  = hit_ctrl | hit_status
                 | (~pwrite & (hit_drop | hit_ts));

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = data_rd & (state_q == IDLE) & ~empty;

  // A push on a CLEAR edge is discarded silently.
  assign push_req  = diag_valid & en_q & ~clear;
  // A simultaneous pop frees a slot, so a full log still accepts.
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & full & ~pop;
  assign push_ovr  = push_drop & ow_q;
  assign mem_we    = push_ok | push_ovr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    en_d     = en_q;
    ow_d     = ow_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    state_d  = state_q;
    if (ctrl_wr) begin
      en_d = pwdata[CTRL_ENABLE];
      ow_d = pwdata[CTRL_OVERWRITE];
    end
    if (stat_wr && pwdata[STAT_OVF]) ovf_d = 1'b0;
    if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop || push_ovr) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop) count_d = count_q + CW'(1);
    if (!push_ok && pop) count_d = count_q - CW'(1);
    // A new drop wins over a same-edge W1C.
    if (push_drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end
    unique case (state_q)
      IDLE:    if (pop) state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      ow_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
      ow_q     <= ow_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

`ifdef DIAG_TIMESTAMP_EN
  logic [31:0] tsc_q;
  logic [31:0] ts_q, ts_d;

  assign hit_ts    = (off == OFF_TS);
  assign mem_wdata = {tsc_q, diag_data};

  always_comb begin
    ts_d = ts_q;
    if (state_q == WAIT) ts_d = mem_rdata[63:32];
    if (clear) ts_d = '0;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tsc_q <= '0;
      ts_q  <= '0;
    end else begin
      tsc_q <= tsc_q + 32'd1;
      ts_q  <= ts_d;
    end
  end
`else
  assign hit_ts    = 1'b0;
  assign mem_wdata = diag_data;
`endif

  diag_fifo_mem #(
    .DEPTH(DEPTH),
    .W    (MEM_W)
  ) u_mem (
    .clk_i  (pclk),
    .rst_i  (preset),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(mem_wdata),
    .re_i   (pop),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    reg_rdata = '0;
    unique case (1'b1)
      hit_ctrl:   reg_rdata = {30'b0, ow_q, en_q};
      hit_status: reg_rdata = {13'b0, ovf_q, full, empty,
                               16'(count_q)};
      hit_drop:   reg_rdata = {16'b0, drop_q};
`ifdef DIAG_TIMESTAMP_EN
      hit_ts:     reg_rdata = ts_q;
`endif
      default:    reg_rdata = '0;
    endcase
  end

  // DATA reads stall one cycle while the pop commits; everything
  // else, including every error, completes in the first cycle.
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (access && !preset) begin
      if (data_rd) begin
        if (state_q == WAIT) begin
          pready = 1'b1;
          prdata = mem_rdata[31:0];
        end else if (empty) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end else begin
        pready  = 1'b1;
        pslverr = ~map_ok;
        if (!pwrite && map_ok) prdata = reg_rdata;
      end
    end
  end

  assign diag_irq = en_q & ((count_q >= CW'(IRQ_LEVEL)) | ovf_q);

endmodule

// File: tb/tb_apb_diag_buffer.sv
// Self-checking bench for apb_diag_buffer (DEPTH=4) against a
// queue-based model of the log, drop counter and overflow flag.
module tb_apb_diag_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0002_B000;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = 4'h3;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        diag_valid = 1'b0;
  logic [31:0] diag_data = '0;
  logic        diag_irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] q[$];
  logic [31:0] tq[$];
  bit          m_en, m_ow, m_ovf;
  int          m_drop;
  logic [31:0] m_ts;

  apb_diag_buffer #(.DEPTH(DEPTH)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .diag_valid(diag_valid),
    .diag_data(diag_data), .diag_irq(diag_irq)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk or posedge preset)
    if (preset) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic void model_clear();
    q.delete();
    tq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_ts   = '0;
  endfunction

  function automatic void m_push(input logic [31:0] d,
                                 input logic [31:0] t);
    if (!m_en) return;
    if (q.size() < DEPTH) begin
      q.push_back(d);
      tq.push_back(t);
    end else begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
      if (m_ow) begin
        q.delete(0);
        tq.delete(0);
        q.push_back(d);
        tq.push_back(t);
      end
    end
  endfunction

  function automatic logic [31:0] m_status();
    int n = q.size();
    return {13'b0, m_ovf, n == DEPTH, n == 0, 16'(n)};
  endfunction

  function automatic logic m_irq();
    return m_en & ((q.size() >= DEPTH / 2) | m_ovf);
  endfunction

  task automatic apb_xfer(input logic [31:0] a, input logic w,
                          input logic [31:0] wd,
                          output logic [31:0] rd,
                          output logic err, output int waits);
    @(posedge pclk); #1;
    paddr = a; pwrite = w; pwdata = wd;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && waits < 8) begin
      waits++;
      @(negedge pclk);
    end
    if (pready !== 1'b1) waits = -1;
    rd = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    logic [31:0] t;
    @(posedge pclk); #1;
    diag_valid = 1'b1;
    diag_data = d;
    t = cyc;
    @(posedge pclk); #1;
    diag_valid = 1'b0;
    m_push(d, t);
  endtask

  task automatic set_ctrl(input bit en, input bit ow, input bit clr);
    logic [31:0] rd;
    logic err;
    int w;
    apb_xfer(BASE, 1'b1, {29'b0, clr, ow, en}, rd, err, w);
    m_en = en;
    m_ow = ow;
    if (clr) model_clear();
  endtask

  task automatic do_reset();
    @(posedge pclk); #1;
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    m_en = 1'b0;
    m_ow = 1'b0;
    model_clear();
  endtask

  // Pops one entry through DATA and checks it against the model.
  task automatic check_pop(input string nm);
    logic [31:0] rd, exp;
    logic err;
    int w;
    apb_xfer(BASE + 32'h8, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (q.size() == 0) begin
      if (w !== 0 || err !== 1'b1 || rd !== '0) begin
        n_bad++;
        $display("FAIL %s empty: w=%0d err=%b d=%h want w=0 err=1 d=0",
                 nm, w, err, rd);
      end
    end else begin
      exp = q[0];
      m_ts = tq[0];
      q.delete(0);
      tq.delete(0);
      if (w !== 1 || err !== 1'b0 || rd !== exp) begin
        n_bad++;
        $display("FAIL %s pop: w=%0d err=%b d=%h want w=1 err=0 d=%h",
                 nm, w, err, rd, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic err;
    int w;
    @(posedge pclk); #1;
    preset = 1'b1;
    paddr = BASE + 32'h4; psel = 1'b1; penable = 1'b1;
    @(negedge pclk);
    n_cmp++;
    if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0 ||
        diag_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs: rdy=%b d=%h err=%b irq=%b want 0",
               pready, prdata, pslverr, diag_irq);
    end
    psel = 1'b0; penable = 1'b0;
    do_reset();
    apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== 32'h0001_0000 || err !== 1'b0 || w !== 0) begin
      n_bad++;
      $display("FAIL reset_status: d=%h err=%b w=%0d want 00010000/0/0",
               rd, err, w);
    end
    n_cmp++;
    if (diag_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_irq: got %b want 0", diag_irq);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic err;
    int w;
    set_ctrl(1'b1, 1'b0, 1'b0);
    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    n_cmp++;
    if (diag_irq !== m_irq()) begin
      n_bad++;
      $display("FAIL basic_irq: got %b want %b", diag_irq, m_irq());
    end
    check_pop("basic");
    n_cmp++;
    if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_outs: rdy=%b d=%h err=%b want 0",
               pready, prdata, pslverr);
    end
    apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== m_status() || rd !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL basic_status: got %h want %h", rd, m_status());
    end
  endtask

  task automatic test_empty();
    logic [31:0] rd;
    logic err;
    int w;
    check_pop("drain");
    check_pop("empty");
    apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== 32'h0001_0000) begin
      n_bad++;
      $display("FAIL empty_status: got %h want 00010000", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic err;
    int w;
    for (int pass = 0; pass < 2; pass++) begin
      set_ctrl(1'b1, pass[0], 1'b1);
      for (int i = 1; i <= 6; i++) push(i);
      apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
      n_cmp++;
      if (rd !== 32'h0006_0004 || rd !== m_status()) begin
        n_bad++;
        $display("FAIL ovf_status%0d: got %h want 00060004", pass, rd);
      end
      apb_xfer(BASE + 32'hC, 1'b0, '0, rd, err, w);
      n_cmp++;
      if (rd !== 32'd2 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL ovf_drop%0d: got %h err=%b want 2", pass, rd, err);
      end
      n_cmp++;
      if (q[0] !== (pass ? 32'd3 : 32'd1)) begin
        n_bad++;
        $display("FAIL ovf_model%0d: got %h", pass, q[0]);
      end
      for (int i = 0; i < 4; i++) check_pop("ovf_pop");
    end
    apb_xfer(BASE + 32'h4, 1'b1, 32'h0004_0000, rd, err, w);
    m_ovf = 1'b0;
    apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== m_status() || diag_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL w1c: got %h irq=%b want %h irq=0",
               rd, diag_irq, m_status());
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] rd, exp, t;
    logic err;
    int w;
    set_ctrl(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push(32'h100 + i);
    @(posedge pclk); #1;
    paddr = BASE + 32'h8; pwrite = 1'b0;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    diag_valid = 1'b1;
    diag_data = 32'h77;
    t = cyc;
    @(negedge pclk);
    n_cmp++;
    if (pready !== 1'b0) begin
      n_bad++;
      $display("FAIL same_wait: pready=%b want 0", pready);
    end
    exp = q[0];
    q.delete(0);
    tq.delete(0);
    m_push(32'h77, t);
    @(posedge pclk); #1;
    diag_valid = 1'b0;
    @(negedge pclk);
    n_cmp++;
    if (pready !== 1'b1 || prdata !== exp || pslverr !== 1'b0) begin
      n_bad++;
      $display("FAIL same_data: rdy=%b d=%h want 1/%h",
               pready, prdata, exp);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== 32'h0002_0004) begin
      n_bad++;
      $display("FAIL same_status: got %h want 00020004", rd);
    end
    apb_xfer(BASE + 32'hC, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_bad++;
      $display("FAIL same_drop: got %h want 0", rd);
    end
    for (int i = 0; i < 4; i++) check_pop("same_pop");
  endtask

  task automatic test_errors();
    logic [31:0] rd, st;
    logic err;
    int w;
    push(32'hBEEF);
    st = m_status();
    apb_xfer(BASE + 32'h8, 1'b1, 32'h1234, rd, err, w);
    n_cmp++;
    if (err !== 1'b1 || w !== 0) begin
      n_bad++;
      $display("FAIL wr_data: err=%b w=%0d want 1/0", err, w);
    end
    apb_xfer(BASE + 32'h20, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (err !== 1'b1 || rd !== '0 || w !== 0) begin
      n_bad++;
      $display("FAIL rd_unmap: err=%b d=%h w=%0d want 1/0/0",
               err, rd, w);
    end
    apb_xfer(BASE + 32'hC, 1'b1, 32'hFFFF, rd, err, w);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_drop: err=%b want 1", err);
    end
    apb_xfer(BASE + 32'h10, 1'b0, '0, rd, err, w);
    n_cmp++;
`ifdef DIAG_TIMESTAMP_EN
    if (err !== 1'b0) begin
`else
    if (err !== 1'b1 || rd !== '0) begin
`endif
      n_bad++;
      $display("FAIL ts_map: err=%b d=%h", err, rd);
    end
    apb_xfer(32'hFFFF_F006, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== st || err !== 1'b0) begin
      n_bad++;
      $display("FAIL alias_status: got %h want %h", rd, st);
    end
    apb_xfer(BASE, 1'b1, 32'h7, rd, err, w);
    m_en = 1'b1; m_ow = 1'b1;
    model_clear();
    apb_xfer(BASE, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== 32'h3 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL ctrl_rd: got %h want 3", rd);
    end
    check_pop("after_clear");
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic err;
    int w, r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        push($urandom);
      end else if (r < 80) begin
        check_pop("rand");
`ifdef DIAG_TIMESTAMP_EN
        apb_xfer(BASE + 32'h10, 1'b0, '0, rd, err, w);
        n_cmp++;
        if (rd !== m_ts) begin
          n_bad++;
          $display("FAIL rand_ts: got %h want %h", rd, m_ts);
        end
`endif
      end else if (r < 90) begin
        apb_xfer(BASE + 32'h4, 1'b0, '0, rd, err, w);
        n_cmp++;
        if (rd !== m_status() || diag_irq !== m_irq()) begin
          n_bad++;
          $display("FAIL rand_status: got %h irq=%b want %h irq=%b",
                   rd, diag_irq, m_status(), m_irq());
        end
        apb_xfer(BASE + 32'hC, 1'b0, '0, rd, err, w);
        n_cmp++;
        if (rd !== 32'(m_drop)) begin
          n_bad++;
          $display("FAIL rand_drop: got %h want %h", rd, m_drop);
        end
      end else if (r < 96) begin
        set_ctrl($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 4) == 0);
      end else begin
        apb_xfer(BASE + 32'h4, 1'b1, 32'h0004_0000, rd, err, w);
        m_ovf = 1'b0;
      end
    end
  endtask

`ifdef DIAG_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] rd;
    logic err;
    int w;
    do_reset();
    apb_xfer(BASE + 32'h10, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== '0) begin
      n_bad++;
      $display("FAIL ts_reset: got %h want 0", rd);
    end
    set_ctrl(1'b1, 1'b0, 1'b0);
    while (cyc < 100) begin
      @(posedge pclk); #1;
    end
    diag_valid = 1'b1;
    diag_data = 32'hCAFE;
    @(posedge pclk); #1;
    diag_valid = 1'b0;
    m_push(32'hCAFE, 32'd100);
    check_pop("ts_pop");
    apb_xfer(BASE + 32'h10, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== 32'd100 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL ts_100: got %0d want 100", rd);
    end
    set_ctrl(1'b1, 1'b0, 1'b1);
    apb_xfer(BASE + 32'h10, 1'b0, '0, rd, err, w);
    n_cmp++;
    if (rd !== '0) begin
      n_bad++;
      $display("FAIL ts_clear: got %h want 0", rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_same_edge();
    test_errors();
    test_random();
`ifdef DIAG_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
